// File: rtl/ones_count_scheduler.sv
// ones_count_scheduler: round-robin front end that shares one ones-count
// engine between N_REQ requesters. It grants one requester, latches its
// operand, pulses eng_start, waits for eng_done and returns the count with a
// one-cycle ack.
// Optional watchdog: define ONES_SCHED_TIMEOUT_EN to abort a stuck WAIT after
// TIMEOUT_CYC cycles (resp_err=1, resp_count=0).
module ones_count_scheduler #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 2*DATA_W+4
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [CNT_W-1:0]        resp_count,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_data,
  input  logic                    eng_rdy,
  input  logic                    eng_done,
  input  logic [CNT_W-1:0]        eng_count
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // A full-scale operand must fit in the result without truncation.
  if (CNT_W < $clog2(DATA_W+1) || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("ones_count_scheduler: CNT_W too narrow or TIMEOUT_CYC < 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [DATA_W-1:0]  eng_data_q, eng_data_d;
  logic [CNT_W-1:0]   resp_count_q, resp_count_d;
  logic               grant_vld;
  logic [IDW-1:0]     grant_id;
  logic [N_REQ-1:0]   ack_one;

`ifdef ONES_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          resp_err_q, resp_err_d;
`endif

  // Round-robin search: walk rr_ptr, rr_ptr+1, ... and keep the nearest hit.
  // Iterating from the farthest offset down lets the closest one win last.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  // Controller next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    eng_data_d   = eng_data_q;
    resp_count_d = resp_count_q;
`ifdef ONES_SCHED_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Only arbitrate when the engine can accept a start right away.
        if (grant_vld && eng_rdy) begin
          id_d       = grant_id;
          eng_data_d = req_data[grant_id*DATA_W +: DATA_W];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ONES_SCHED_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (eng_done) begin
          resp_count_d = eng_count;
          state_d      = S_RESP;
`ifdef ONES_SCHED_TIMEOUT_EN
          resp_err_d   = 1'b0;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYC)) begin
          // Abandon the engine; any late eng_done lands outside WAIT.
          resp_count_d = '0;
          resp_err_d   = 1'b1;
          state_d      = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        // Winner goes to the back of the queue.
        rr_ptr_d     = (id_q == IDW'(N_REQ-1)) ? '0 : id_q + 1'b1;
        resp_count_d = '0;
`ifdef ONES_SCHED_TIMEOUT_EN
        resp_err_d   = 1'b0;
`endif
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      eng_data_q   <= '0;
      resp_count_q <= '0;
`ifdef ONES_SCHED_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      eng_data_q   <= eng_data_d;
      resp_count_q <= resp_count_d;
`ifdef ONES_SCHED_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign ack_one    = N_REQ'(1) << id_q;
  assign ack        = (state_q == S_RESP) ? ack_one : '0;
  assign resp_count = resp_count_q;
  assign busy       = (state_q != S_IDLE);
  assign eng_start  = (state_q == S_ISSUE);
  assign eng_data   = eng_data_q;
`ifdef ONES_SCHED_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ones_count_scheduler.sv
// Bench for ones_count_scheduler: behavioural engine model plus a scoreboard
// of expected operands (checked at eng_start) and responses (checked at ack).
module tb_ones_count_scheduler;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int TMO    = 2*DATA_W+4;

  logic                    clk = 1'b0;
  logic                    rstb = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        ack;
  logic [CNT_W-1:0]        resp_count;
  logic                    resp_err, busy, eng_start;
  logic [DATA_W-1:0]       eng_data;
  logic                    eng_rdy;
  logic                    eng_done = 1'b0;
  logic [CNT_W-1:0]        eng_count = '0;

  always #5 clk = ~clk;

  ones_count_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstb(rstb), .req(req), .req_data(req_data), .ack(ack),
    .resp_count(resp_count), .resp_err(resp_err), .busy(busy),
    .eng_start(eng_start), .eng_data(eng_data), .eng_rdy(eng_rdy),
    .eng_done(eng_done), .eng_count(eng_count)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int popc(input logic [DATA_W-1:0] v);
    int c = 0;
    for (int i = 0; i < DATA_W; i++) c += int'(v[i]);
    return c;
  endfunction

  // Engine model: not reset by the scheduler, so it runs on its own.
  logic              rdy_en = 1'b1, eng_hang = 1'b0, eng_kill = 1'b0;
  logic              m_busy = 1'b0;
  int                m_cnt = 0;
  int                eng_lat = 10;
  logic [DATA_W-1:0] m_data = '0;
  assign eng_rdy = rdy_en & ~m_busy;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (eng_kill) m_busy <= 1'b0;
    else if (eng_start && !m_busy) begin
      m_busy <= 1'b1; m_cnt <= eng_lat; m_data <= eng_data;
    end else if (m_busy && !eng_hang) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0; eng_done <= 1'b1; eng_count <= CNT_W'(popc(m_data));
      end else m_cnt <= m_cnt - 1;
    end
  end

  typedef struct {
    logic [N_REQ-1:0] ack;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;
  exp_t              sbq[$];
  logic [DATA_W-1:0] eq[$];
  exp_t              e;
  logic [DATA_W-1:0] ev;
  int                cyc = 0, done_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_svc(input int id, input logic [DATA_W-1:0] op, input logic err);
    exp_t x;
    x.ack = N_REQ'(1) << id;
    x.cnt = err ? '0 : CNT_W'(popc(op));
    x.err = err;
    eq.push_back(op);
    sbq.push_back(x);
  endtask

  // Monitor: compare operand at each start and response at each ack.
  always @(negedge clk) begin
    if (rstb) begin
      if (eng_done) done_cyc = cyc;
      if (eng_start) begin
        if (eq.size() == 0) chk("start_unexpected", 32'(eng_start), 0);
        else begin ev = eq.pop_front(); chk("eng_data", 32'(eng_data), 32'(ev)); end
      end
      if (ack != '0) begin
        if (sbq.size() == 0) chk("ack_unexpected", 32'(ack), 0);
        else begin
          e = sbq.pop_front();
          chk("ack", 32'(ack), 32'(e.ack));
          chk("resp_count", 32'(resp_count), 32'(e.cnt));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          if (!e.err) chk("done_to_ack", 32'(cyc - done_cyc), 1);
        end
      end
    end
  end

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin @(negedge clk); #1; n++; end
    if (sbq.size() != 0) begin chk("ack_timeout", 32'(sbq.size()), 0); sbq.delete(); end
    req = '0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (eq.size() != 0 && n < budget) begin @(negedge clk); #1; n++; end
    if (eq.size() != 0) begin chk("start_timeout", 32'(eq.size()), 0); eq.delete(); end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstb = 1'b0; req = '0; sbq.delete(); eq.delete();
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
  endtask

  logic [DATA_W-1:0] ops [N_REQ];
  int                s;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_data", 32'(eng_data), 0);
    chk("rst_count", 32'(resp_count), 0);
    chk("rst_err", 32'(resp_err), 0);
    rstb = 1'b1;

    // 1: idle with no requests
    repeat (20) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ack", 32'(ack), 0);
      chk("idle_start", 32'(eng_start), 0);
    end

    // 2: single request from requester 2
    @(posedge clk); #1;
    req_data[2*DATA_W +: DATA_W] = 8'hB2;
    push_svc(2, 8'hB2, 1'b0);
    req = 4'b0100;
    @(negedge clk); chk("t2_start_early", 32'(eng_start), 0);
    @(negedge clk); chk("t2_start_lat", 32'(eng_start), 1);
    wait_sb(60);

    // 3: all requesting, round-robin 0,1,2,3,0,1 with full-scale operand
    do_reset();
    ops[0] = 8'hFF; ops[1] = 8'h00; ops[2] = 8'h5A; ops[3] = 8'h81;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = ops[i];
    for (int k = 0; k < 6; k++) push_svc(k % N_REQ, ops[k % N_REQ], 1'b0);
    req = 4'b1111;
    wait_sb(400);

    // 4: engine not ready holds off the grant
    do_reset();
    rdy_en = 1'b0;
    req_data[1*DATA_W +: DATA_W] = 8'h3C;
    push_svc(1, 8'h3C, 1'b0);
    req = 4'b0010;
    repeat (10) begin
      @(negedge clk);
      chk("t4_no_start", 32'(eng_start), 0);
      chk("t4_not_busy", 32'(busy), 0);
    end
    @(posedge clk); #1 rdy_en = 1'b1;
    @(negedge clk); chk("t4_start_early", 32'(eng_start), 0);
    @(negedge clk); chk("t4_start_lat", 32'(eng_start), 1);
    wait_sb(60);

    // 5: reset during WAIT, then rr pointer must restart at 0
    do_reset();
    req_data[2*DATA_W +: DATA_W] = 8'h07;
    push_svc(2, 8'h07, 1'b0);
    req = 4'b0100;
    wait_sb(60);
    eng_lat = 30;
    req_data[1*DATA_W +: DATA_W] = 8'hF0;
    eq.push_back(8'hF0);
    req = 4'b0010;
    wait_start(20);
    repeat (3) @(posedge clk);
    #1 rstb = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ack", 32'(ack), 0);
    chk("t5_start", 32'(eng_start), 0);
    chk("t5_data", 32'(eng_data), 0);
    chk("t5_count", 32'(resp_count), 0);
    chk("t5_err", 32'(resp_err), 0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    eng_lat = 10;
    req_data[0*DATA_W +: DATA_W] = 8'h11;
    req_data[3*DATA_W +: DATA_W] = 8'hE7;
    push_svc(0, 8'h11, 1'b0);
    push_svc(3, 8'hE7, 1'b0);
    req = 4'b1001;
    wait_sb(200);
    repeat (5) @(negedge clk);
    chk("t5_idle_count", 32'(resp_count), 0);

    // 6: engine never completes
    do_reset();
    eng_hang = 1'b1;
    req_data[0*DATA_W +: DATA_W] = 8'h55;
`ifdef ONES_SCHED_TIMEOUT_EN
    push_svc(0, 8'h55, 1'b1);
    req = 4'b0001;
    wait_start(20);
    s = cyc;
    for (int n = 0; n < 100 && ack == '0; n++) begin @(negedge clk); #1; end
    chk("t6_tmo_lat", 32'(cyc - s), 32'(TMO + 2));
    wait_sb(5);
`else
    eq.push_back(8'h55);
    req = 4'b0001;
    wait_start(20);
    repeat (50) begin
      @(negedge clk);
      chk("t6_busy_hold", 32'(busy), 1);
    end
    req = '0;
`endif
    @(posedge clk); #1 eng_kill = 1'b1; eng_hang = 1'b0;
    @(posedge clk); #1 eng_kill = 1'b0;
    do_reset();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
